cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer_pkg.sv | 22 ++
 rtl/cpu_bus_mux.sv | 42 ++++
 rtl/cpu_sequencer.sv | 101 ++++++++++
 tb/tb_cpu_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the nqcpu sequencer: state bit indices, vector widths
// and a helper that builds a one-hot state word from a bit index.
package cpu_sequencer_pkg;

    localparam int BUS_W   = 16;
    localparam int STATE_W = 10;

    localparam int ST_RESET = 0;
    localparam int ST_FETCH = 1;
    localparam int ST_DECODE = 2;
    localparam int ST_ALU   = 3;
    localparam int ST_MEM   = 4;
    localparam int ST_WB    = 5;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [BUS_W-1:0]   word_t;

    function automatic state_t st_bit(input int idx);
        return state_t'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_bus_mux.sv
// Combinational arbitration of the fetch and memory stages onto the single
// external bus, plus tristate control of the shared data lines.
module cpu_bus_mux
    import cpu_sequencer_pkg::*;
(
    input  logic             fetch_en,
    input  logic             mem_en,
    input  logic [BUS_W-1:0] fetch_addr,
    input  logic             fetch_re,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic             mem_re,
    input  logic             mem_we,
    input  logic [BUS_W-1:0] mem_dataOut,
    output logic [BUS_W-1:0] addr_o,
    output logic             re_o,
    output logic             we_o,
    inout  logic [BUS_W-1:0] data_io,
    output logic [BUS_W-1:0] dataRead
);

    logic drive_data;

    always_comb begin
        addr_o = '0;
        re_o   = 1'b0;
        we_o   = 1'b0;
        if (fetch_en) begin
            addr_o = fetch_addr;
            re_o   = fetch_re;
        end else if (mem_en) begin
            addr_o = mem_addr;
            re_o   = mem_re;
            we_o   = mem_we;
        end
    end

    // Only a memory-stage write owns the data lines; everything else leaves them to the bus.
    assign drive_data = mem_en & mem_we;
    assign data_io    = drive_data ? mem_dataOut : {BUS_W{1'bz}};
    assign dataRead   = data_io;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle stage sequencer for nqcpu: one-hot FSM, stage enables, PC strobe
// and wait qualification, with bus arbitration delegated to cpu_bus_mux.
//
//   state  | meaning
//   RESET  | held in reset or waiting for the synchronised release
//   FETCH  | instruction read on the bus, stalls while waited
//   DECODE | decode stage enabled
//   ALU    | ALU stage enabled, mem_op_next picks MEM or WB
//   MEM    | memory stage owns the bus, stalls while waited
//   WB     | register write-back
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_op_next,
    input  logic [BUS_W-1:0] fetch_addr,
    input  logic             fetch_re,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic             mem_re,
    input  logic             mem_we,
    input  logic [BUS_W-1:0] mem_dataOut,
    input  logic             needWait_i,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             alu_en,
    output logic             mem_en,
    output logic             reg_write_en,
    output logic             incr_pc,
    output logic             needWait_o,
    output logic [BUS_W-1:0] dataRead,
    output logic [BUS_W-1:0] addr_o,
    output logic             re_o,
    output logic             we_o,
    inout  logic [BUS_W-1:0] data_io,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [STATE_W-1:0] S_RESET  = st_bit(ST_RESET);
    localparam logic [STATE_W-1:0] S_FETCH  = st_bit(ST_FETCH);
    localparam logic [STATE_W-1:0] S_DECODE = st_bit(ST_DECODE);
    localparam logic [STATE_W-1:0] S_ALU    = st_bit(ST_ALU);
    localparam logic [STATE_W-1:0] S_MEM    = st_bit(ST_MEM);
    localparam logic [STATE_W-1:0] S_WB     = st_bit(ST_WB);

    logic [STATE_W-1:0] state_q, state_d;
    logic               run_q, run_d;

    // run_q delays reset release by one edge so FETCH begins on the second edge.
    assign run_d = 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  if (run_q) state_d = S_FETCH;
            S_FETCH:  if (!needWait_o) state_d = S_DECODE;
            S_DECODE: state_d = S_ALU;
            S_ALU:    state_d = mem_op_next ? S_MEM : S_WB;
            S_MEM:    if (!needWait_o) state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign fetch_en     = state_q[ST_FETCH];
    assign decode_en    = state_q[ST_DECODE];
    assign alu_en       = state_q[ST_ALU];
    assign mem_en       = state_q[ST_MEM];
    assign reg_write_en = state_q[ST_WB];
    assign dbg_state    = state_q;

    assign needWait_o = needWait_i & (re_o | we_o);
    assign incr_pc    = fetch_en & ~needWait_o;

    cpu_bus_mux u_bus_mux (
        .fetch_en    (fetch_en),
        .mem_en      (mem_en),
        .fetch_addr  (fetch_addr),
        .fetch_re    (fetch_re),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_dataOut (mem_dataOut),
        .addr_o      (addr_o),
        .re_o        (re_o),
        .we_o        (we_o),
        .data_io     (data_io),
        .dataRead    (dataRead)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a driver steps a stage-level reference
// model and queues expected outputs; a negedge monitor pops and compares.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_op_next = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_re = 1'b0;
    logic [15:0] mem_addr = '0;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_dataOut = '0;
    logic        needWait_i = 1'b0;
    logic        ext_en = 1'b0;
    logic [15:0] ext_data = '0;

    logic        fetch_en, decode_en, alu_en, mem_en, reg_write_en;
    logic        incr_pc, needWait_o, re_o, we_o;
    logic [15:0] dataRead, addr_o;
    logic [9:0]  dbg_state;
    wire  [15:0] data_io;

    assign data_io = ext_en ? ext_data : 16'hzzzz;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_op_next  (mem_op_next),
        .fetch_addr   (fetch_addr),
        .fetch_re     (fetch_re),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_dataOut  (mem_dataOut),
        .needWait_i   (needWait_i),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .alu_en       (alu_en),
        .mem_en       (mem_en),
        .reg_write_en (reg_write_en),
        .incr_pc      (incr_pc),
        .needWait_o   (needWait_o),
        .dataRead     (dataRead),
        .addr_o       (addr_o),
        .re_o         (re_o),
        .we_o         (we_o),
        .data_io      (data_io),
        .dbg_state    (dbg_state)
    );

    typedef struct {
        logic [9:0]  dbg;
        logic [4:0]  en;
        logic        incr;
        logic        nwo;
        logic [15:0] addr;
        logic        re;
        logic        we;
        logic [15:0] data;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model: pipeline phase 0..5 = reset, fetch, decode, alu, mem, wb.
    int   m_stage = 0;
    bit   m_armed = 1'b0;
    int   wait_left = 0;

    function automatic exp_t model_out();
        exp_t e;
        bit f = (m_stage == 1);
        bit m = (m_stage == 4);
        e.dbg  = 10'd1 << m_stage;
        e.en   = (m_stage == 0) ? 5'd0 : 5'd1 << (m_stage - 1);
        e.addr = f ? fetch_addr : (m ? mem_addr : 16'h0000);
        e.re   = f ? fetch_re : (m ? mem_re : 1'b0);
        e.we   = m ? mem_we : 1'b0;
        e.nwo  = needWait_i & (e.re | e.we);
        e.incr = f & ~e.nwo;
        e.data = (m && mem_we) ? mem_dataOut : (ext_en ? ext_data : 16'hzzzz);
        return e;
    endfunction

    task automatic advance_model();
        exp_t e = model_out();
        case (m_stage)
            0: begin
                if (m_armed) m_stage = 1;
                m_armed = 1'b1;
            end
            1: if (!e.nwo) m_stage = 2;
            2: m_stage = 3;
            3: m_stage = mem_op_next ? 4 : 5;
            4: if (!e.nwo) m_stage = 5;
            default: m_stage = 1;
        endcase
    endtask

    // mode 0 quiet, 1 random, 2 mem write held by wait, 3 fetch wait, 4 fetch go, 5 mem read with waits
    task automatic step(input int mode, input logic rst_val);
        @(posedge clk);
        if (rst_n) advance_model();
        #1;
        rst_n       = rst_val;
        fetch_addr  = 16'($urandom);
        fetch_re    = ($urandom_range(0, 3) != 0);
        mem_addr    = 16'($urandom);
        mem_re      = 1'($urandom);
        mem_we      = 1'($urandom);
        mem_dataOut = 16'($urandom);
        mem_op_next = 1'($urandom);
        needWait_i  = ($urandom_range(0, 2) == 0);
        ext_data    = 16'($urandom);
        if (!rst_n) begin
            m_stage = 0;
            m_armed = 1'b0;
        end
        ext_en = 1'($urandom);
        case (mode)
            0: begin
                needWait_i  = 1'b0;
                mem_op_next = 1'b0;
            end
            2: begin
                mem_op_next = 1'b1;
                mem_we      = 1'b1;
                mem_re      = 1'b0;
                mem_addr    = 16'h1234;
                mem_dataOut = 16'hBEEF;
                needWait_i  = (m_stage == 4);
                ext_en      = 1'b0;
            end
            3, 4: begin
                fetch_addr = 16'h0010;
                fetch_re   = 1'b1;
                needWait_i = (mode == 3);
            end
            5: begin
                mem_op_next = 1'b1;
                mem_re      = 1'b1;
                mem_we      = 1'b0;
                ext_en      = 1'b1;
                ext_data    = 16'h5A5A;
                needWait_i  = (m_stage == 4) && (wait_left > 0);
                if (needWait_i) wait_left--;
            end
            default: ;
        endcase
        if (m_stage == 4 && mem_we) ext_en = 1'b0;
        q_exp.push_back(model_out());
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int want);
        n_tests++;
        if (m_stage != want) begin
            n_fail++;
            $display("FAIL %s: stage %0d expected %0d", name, m_stage, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("dbg_state", 16'(dbg_state), 16'(e.dbg));
                chk("enables", 16'({reg_write_en, mem_en, alu_en, decode_en, fetch_en}), 16'(e.en));
                chk("incr_pc", 16'(incr_pc), 16'(e.incr));
                chk("needWait_o", 16'(needWait_o), 16'(e.nwo));
                chk("addr_o", addr_o, e.addr);
                chk("re_o", 16'(re_o), 16'(e.re));
                chk("we_o", 16'(we_o), 16'(e.we));
                chk("data_io", data_io, e.data);
                chk("dataRead", dataRead, e.data);
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) step(0, 1'b0);
        for (int i = 0; i < 12; i++) step(0, 1'b1);
        for (int i = 0; i < 400; i++) step(1, 1'b1);

        // Memory write stalled by a wait, then reset pulled mid-MEM.
        for (int i = 0; i < 12 && m_stage != 4; i++) step(2, 1'b1);
        bound_fail("reach_mem_write", 4);
        step(2, 1'b1);
        step(2, 1'b0);
        step(0, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 1'b1);

        // Fetch held three cycles by wait, released on the fourth.
        for (int i = 0; i < 12 && m_stage != 5; i++) step(0, 1'b1);
        bound_fail("reach_wb", 5);
        for (int i = 0; i < 3; i++) step(3, 1'b1);
        step(4, 1'b1);

        // Memory read from an externally driven bus with two wait cycles.
        wait_left = 2;
        for (int i = 0; i < 12 && !(m_stage == 5 && wait_left == 0); i++) step(5, 1'b1);
        bound_fail("mem_read_done", 5);

        for (int i = 0; i < 200; i++) step(1, 1'b1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
